dvp_cam_tx: RTL and testbench
=============================

Name: dvp_cam_tx

Overview:
- DVP camera-side transmitter (emulator) driving VSYNC/HREF/8-bit data on a single pixel clock, with OV7660-style framing.
- Pixel bytes come from an upstream stream (pattern generator or replay buffer) via valid/ready.
- Loops back into the capture path, so the capture chain is exercised without a sensor, in hardware and in simulation.

Parameters:
- HLEN, 1280: data bytes per line (HREF-high cycles); must be >= 1.
- VLEN, 480: active lines per frame; must be >= 1.
- HBLANK_CYC, 144: HREF-low cycles after every line, including the last; must be >= 1.
- VSYNC_CYC, 1568: VSYNC-high cycles at frame start; must be >= 1.
- VBP_CYC, 1568: cycles between VSYNC fall and the first HREF; must be >= 1.
- VFP_CYC, 784: cycles after the last HBLANK before the next VSYNC or IDLE; must be >= 1.
- CW, 16: width of the internal counters; every length parameter must fit in CW bits.

Ports:
- pclk  in  1  pixel clock, the only clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins streaming when idle.
- stop  in  1  one-cycle pulse; ends streaming at the next frame end.
- pix  in  8  pixel byte.
- pix_valid  in  1  pix is valid.
- pix_ready  out  1  byte consumed this cycle.
- cam_vsync  out  1  VSYNC, registered.
- cam_href  out  1  HREF, registered.
- cam_dout  out  8  data byte, registered.
- busy  out  1  state != IDLE.
- underflow  out  1  sticky: an active byte was needed while pix_valid was low.
- frame_cnt  out  CW  completed frames, wraps modulo 2^CW.

Behaviour:
- Reset (async assert, sync release to pclk):
  - state=IDLE.
  - All counters 0.
  - cam_vsync=0, cam_href=0, cam_dout=0.
  - pix_ready=0, busy=0, underflow=0, frame_cnt=0, stop_pending=0.
- FSM states: IDLE, VSYNC, VBP, ACTIVE, HBLANK, VFP.
  - Each state holds for its parameter length using a down-counter `cyc`, loaded on entry with len-1; exit happens when cyc==0.
  - IDLE -> VSYNC: on start.
    - Same edge: underflow cleared, stop_pending <= stop.
  - VSYNC (VSYNC_CYC) -> VBP (VBP_CYC) -> ACTIVE.
  - ACTIVE (HLEN) -> HBLANK (HBLANK_CYC).
  - HBLANK -> ACTIVE if row != VLEN-1 (row increments); otherwise -> VFP.
  - VFP (VFP_CYC): at exit, frame_cnt increments.
    - Then -> IDLE if stop_pending (stop_pending cleared); otherwise -> VSYNC.
- Output registers: cam_vsync and cam_href are the registered decode of the current state (1 in VSYNC, 1 in ACTIVE respectively).
  - Every waveform is therefore delayed exactly 1 cycle from the state, and HREF and data stay mutually aligned.
- pix_ready = (state==ACTIVE), combinational; a byte transfers on pix_valid && pix_ready.
- cam_dout:
  - In ACTIVE: registered pix if pix_valid, else 8'h00 and underflow <= 1.
  - Outside ACTIVE: registered 8'h00.
- Underflow never stalls timing: the line length is always exactly HLEN.
- Frame period = VSYNC_CYC + VBP_CYC + VLEN*(HLEN+HBLANK_CYC) + VFP_CYC cycles. The first cam_vsync high occurs 2 cycles after the start pulse.
- start while busy: ignored.
- stop while busy: sets stop_pending. stop in IDLE without start: ignored.
- start+stop in the same IDLE cycle: runs exactly one frame, then returns to IDLE.
- Reset mid-frame: outputs return to their reset values immediately (asynchronously). No partial-frame completion.
- underflow is cleared only by reset or by an accepted start.

Decomposition:
- Shared package:
  - state enum (ST_IDLE..ST_VFP, 3 bits)
  - DVP_DATA_W=8
  - default timing constants for the OV7660 VGA YUV mode
- Natural sub-module: dvp_timing_cnt. It is the parameterised down-counter with load/zero flag, used for `cyc` and reused by other timing generators. Row and column logic stay in the top level.

Test Plan:
Common parameters: HLEN=4, VLEN=2, HBLANK_CYC=3, VSYNC_CYC=2, VBP_CYC=2, VFP_CYC=1, so frame=19 cycles.
- Start+stop at cycle 0, pix_valid held 1, pix=0x10,0x11,... -> cam_vsync high cycles 2-3; cam_href high cycles 6-9 and 13-16; cam_dout=10,11,12,13 then 14,15,16,17; frame_cnt=1; busy low from cycle 20; underflow=0.
- start only, stop pulsed at cycle 25 -> two back-to-back frames, second VSYNC high cycles 21-22; idle after cycle 39; frame_cnt=2.
- pix_valid deasserted during the 2nd byte of line 0 -> cam_dout=10,00,11,12; underflow=1; HREF width still 4; underflow cleared by the next start.
- start pulsed while busy at cycles 5 and 12 -> no timing change versus the first scenario; frame_cnt=1.
- rst asserted at cycle 8 (mid-HREF) -> cam_href=0, cam_dout=0, busy=0 asynchronously; the next start produces a clean frame from VSYNC.
- Defaults HLEN=1280, VLEN=480, looped into the capture path -> capture reports hlen=1280, vlen=480; bytes match the source.

Source files
------------

// File: rtl/dvp_cam_tx_pkg.sv
// Shared constants for the DVP camera-side transmitter.
package dvp_cam_tx_pkg;

    localparam int unsigned DVP_DATA_W = 8;
    localparam int unsigned STATE_W    = 3;

    // Frame FSM states
    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_VSYNC  = 3'd1;
    localparam logic [STATE_W-1:0] ST_VBP    = 3'd2;
    localparam logic [STATE_W-1:0] ST_ACTIVE = 3'd3;
    localparam logic [STATE_W-1:0] ST_HBLANK = 3'd4;
    localparam logic [STATE_W-1:0] ST_VFP    = 3'd5;

    // Default timing: OV7660 VGA YUV (two bytes per pixel)
    localparam int unsigned DEF_HLEN       = 1280;
    localparam int unsigned DEF_VLEN       = 480;
    localparam int unsigned DEF_HBLANK_CYC = 144;
    localparam int unsigned DEF_VSYNC_CYC  = 1568;
    localparam int unsigned DEF_VBP_CYC    = 1568;
    localparam int unsigned DEF_VFP_CYC    = 784;
    localparam int unsigned DEF_CW         = 16;

endpackage

// File: rtl/dvp_timing_cnt.sv
// Loadable down-counter that stops at zero; zero_c flags the last cycle of a phase.
module dvp_timing_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero_c
);

    logic [W-1:0] cnt;

    // Load on phase entry, otherwise count down and hold at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (!zero_c) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/dvp_cam_tx.sv
// DVP camera emulator: VSYNC/HREF/data framing from a valid/ready byte stream.
module dvp_cam_tx
    import dvp_cam_tx_pkg::*;
#(
    parameter int unsigned HLEN       = DEF_HLEN,
    parameter int unsigned VLEN       = DEF_VLEN,
    parameter int unsigned HBLANK_CYC = DEF_HBLANK_CYC,
    parameter int unsigned VSYNC_CYC  = DEF_VSYNC_CYC,
    parameter int unsigned VBP_CYC    = DEF_VBP_CYC,
    parameter int unsigned VFP_CYC    = DEF_VFP_CYC,
    parameter int unsigned CW         = DEF_CW
) (
    input  logic                  pclk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [DVP_DATA_W-1:0] pix,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    output logic                  cam_vsync,
    output logic                  cam_href,
    output logic [DVP_DATA_W-1:0] cam_dout,
    output logic                  busy,
    output logic                  underflow,
    output logic [CW-1:0]         frame_cnt
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic               cyc_zero;
    logic               cyc_load;
    logic [CW-1:0]      cyc_load_val;
    logic [CW-1:0]      row;
    logic               stop_pending;
    logic               last_row;
    logic               frame_end;

    assign last_row  = (row == CW'(VLEN - 1));
    assign frame_end = (state == ST_VFP) && cyc_zero;

    // Phase length counter
    dvp_timing_cnt #(.W(CW)) u_cyc (
        .clk      (pclk),
        .rst      (rst),
        .load     (cyc_load),
        .load_val (cyc_load_val),
        .zero_c   (cyc_zero)
    );

    // State register
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and phase-counter reload
    always_comb begin
        state_nxt    = state;
        cyc_load     = 1'b0;
        cyc_load_val = '0;
        case (state)
            ST_IDLE:   if (start)    state_nxt = ST_VSYNC;
            ST_VSYNC:  if (cyc_zero) state_nxt = ST_VBP;
            ST_VBP:    if (cyc_zero) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (cyc_zero) state_nxt = ST_HBLANK;
            ST_HBLANK: if (cyc_zero) state_nxt = last_row ? ST_VFP : ST_ACTIVE;
            ST_VFP:    if (cyc_zero) state_nxt = stop_pending ? ST_IDLE : ST_VSYNC;
            default:   state_nxt = ST_IDLE;
        endcase
        // Every transition enters a new phase, so reload on any state change
        cyc_load = (state_nxt != state);
        case (state_nxt)
            ST_VSYNC:  cyc_load_val = CW'(VSYNC_CYC - 1);
            ST_VBP:    cyc_load_val = CW'(VBP_CYC - 1);
            ST_ACTIVE: cyc_load_val = CW'(HLEN - 1);
            ST_HBLANK: cyc_load_val = CW'(HBLANK_CYC - 1);
            ST_VFP:    cyc_load_val = CW'(VFP_CYC - 1);
            default:   cyc_load_val = '0;
        endcase
    end

    // Row index, advanced at each line end and rewound after the last line
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            row <= '0;
        end else if ((state == ST_HBLANK) && cyc_zero) begin
            row <= last_row ? '0 : row + CW'(1);
        end
    end

    // Stop request latch, start-time underflow clear and frame counter
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            stop_pending <= 1'b0;
            underflow    <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            if (state == ST_IDLE) begin
                if (start) begin
                    stop_pending <= stop;
                    underflow    <= 1'b0;
                end
            end else if (frame_end && stop_pending) begin
                stop_pending <= 1'b0;
            end else if (stop) begin
                stop_pending <= 1'b1;
            end
            if ((state == ST_ACTIVE) && !pix_valid) begin
                underflow <= 1'b1;
            end
            if (frame_end) begin
                frame_cnt <= frame_cnt + CW'(1);
            end
        end
    end

    // Registered DVP outputs; status flags track the state register
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            cam_vsync <= 1'b0;
            cam_href  <= 1'b0;
            cam_dout  <= '0;
            pix_ready <= 1'b0;
            busy      <= 1'b0;
        end else begin
            cam_vsync <= (state == ST_VSYNC);
            cam_href  <= (state == ST_ACTIVE);
            cam_dout  <= ((state == ST_ACTIVE) && pix_valid) ? pix : '0;
            pix_ready <= (state_nxt == ST_ACTIVE);
            busy      <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_dvp_cam_tx.sv
// Randomized self-checking bench for dvp_cam_tx against a frame-timing model.
module tb_dvp_cam_tx;

    localparam int H     = 4;
    localparam int V     = 2;
    localparam int HB    = 3;
    localparam int VS    = 2;
    localparam int VBP   = 2;
    localparam int VFP   = 1;
    localparam int FRAME = VS + VBP + V * (H + HB) + VFP;
    localparam int NMAX  = 128;

    localparam int PH_IDLE = 0;
    localparam int PH_VS   = 1;
    localparam int PH_BL   = 2;
    localparam int PH_ACT  = 3;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [7:0]  pix = 8'h00;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_dout;
    logic        busy;
    logic        underflow;
    logic [15:0] frame_cnt;

    int checks = 0;
    int failures = 0;

    // Stimulus, observations and model configuration
    logic        start_a [NMAX];
    logic        stop_a  [NMAX];
    logic        valid_a [NMAX];
    logic [7:0]  pix_a   [NMAX];
    logic [28:0] obs_a   [NMAX];
    int          s_cyc;
    int          nf;
    int          fc_base;
    logic        uf_carry;

    dvp_cam_tx #(
        .HLEN(H), .VLEN(V), .HBLANK_CYC(HB), .VSYNC_CYC(VS),
        .VBP_CYC(VBP), .VFP_CYC(VFP), .CW(16)
    ) dut (
        .pclk(pclk), .rst(rst), .start(start), .stop(stop), .pix(pix),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .cam_vsync(cam_vsync),
        .cam_href(cam_href), .cam_dout(cam_dout), .busy(busy),
        .underflow(underflow), .frame_cnt(frame_cnt)
    );

    always #5 pclk = ~pclk;

    // Frame phase the transmitter is in during cycle c
    function automatic int phase_at(input int c);
        int t;
        int r;
        t = c - s_cyc - 1;
        if (t < 0 || t >= nf * FRAME) return PH_IDLE;
        r = t % FRAME;
        if (r < VS) return PH_VS;
        r = r - VS - VBP;
        if (r < 0) return PH_BL;
        if (r < V * (H + HB) && (r % (H + HB)) < H) return PH_ACT;
        return PH_BL;
    endfunction

    // Expected {vsync, href, dout, ready, busy, underflow, frame_cnt} in cycle c
    function automatic logic [28:0] exp_at(input int c);
        int         p0;
        int         p1;
        int         t;
        int         done;
        logic [7:0] d;
        logic       uf;
        p0 = phase_at(c - 1);
        p1 = phase_at(c);
        d  = 8'h00;
        if (p0 == PH_ACT && valid_a[c - 1]) d = pix_a[c - 1];
        t    = c - s_cyc - 1;
        done = (t <= 0 || nf == 0) ? 0 : t / FRAME;
        if (done > nf) done = nf;
        if (nf == 0 || c <= s_cyc) begin
            uf = uf_carry;
        end else begin
            uf = 1'b0;
            for (int k = s_cyc + 1; k < c; k++)
                if (phase_at(k) == PH_ACT && !valid_a[k]) uf = 1'b1;
        end
        return {p0 == PH_VS, p0 == PH_ACT, d, p1 == PH_ACT, p1 != PH_IDLE, uf,
                16'(fc_base + done)};
    endfunction

    task automatic clear_stim(input bit rand_valid);
        for (int c = 0; c < NMAX; c++) begin
            start_a[c] = 1'b0;
            stop_a[c]  = 1'b0;
            valid_a[c] = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            pix_a[c]   = 8'($urandom);
        end
    endtask

    // Drive the stimulus tables and record outputs at each falling edge
    task automatic run(input bit do_reset, input int ncyc);
        if (do_reset) begin
            rst = 1'b1;
            start = 1'b0; stop = 1'b0; pix_valid = 1'b0; pix = 8'h00;
            repeat (2) @(negedge pclk);
            rst = 1'b0;
        end
        for (int c = 0; c < ncyc; c++) begin
            obs_a[c]  = {cam_vsync, cam_href, cam_dout, pix_ready, busy, underflow, frame_cnt};
            start     = start_a[c];
            stop      = stop_a[c];
            pix_valid = valid_a[c];
            pix       = pix_a[c];
            @(negedge pclk);
        end
        start = 1'b0; stop = 1'b0; pix_valid = 1'b0;
    endtask

    task automatic test_reset();
        clear_stim(1'b0);
        s_cyc = -1; nf = 0; fc_base = 0; uf_carry = 1'b0;
        run(1'b1, 3);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (obs_a[c] !== 29'h0) begin
                failures++;
                $display("FAIL reset cyc=%0d got=%h exp=%h", c, obs_a[c], 29'h0);
            end
        end
    endtask

    task automatic test_single_frame();
        clear_stim(1'b0);
        start_a[0] = 1'b1; stop_a[0] = 1'b1;
        s_cyc = 0; nf = 1; fc_base = 0; uf_carry = 1'b0;
        run(1'b1, 30);
        for (int c = 0; c < 30; c++) begin
            checks++;
            if (obs_a[c] !== exp_at(c)) begin
                failures++;
                $display("FAIL single_frame cyc=%0d got=%h exp=%h", c, obs_a[c], exp_at(c));
            end
        end
        checks++;
        if (obs_a[29][15:0] !== 16'd1 || obs_a[29][17] !== 1'b0) begin
            failures++;
            $display("FAIL single_frame_end got_cnt=%0d got_busy=%b exp_cnt=1 exp_busy=0",
                     obs_a[29][15:0], obs_a[29][17]);
        end
    endtask

    task automatic test_back_to_back();
        int p;
        for (int it = 0; it < 3; it++) begin
            clear_stim(1'b0);
            p = (it == 0) ? 25 : ((it == 1) ? FRAME : $urandom_range(1, 3 * FRAME - 1));
            start_a[0] = 1'b1; stop_a[p] = 1'b1;
            s_cyc = 0; nf = p / FRAME + 1; fc_base = 0; uf_carry = 1'b0;
            run(1'b1, 1 + nf * FRAME + 4);
            for (int c = 0; c < 1 + nf * FRAME + 4; c++) begin
                checks++;
                if (obs_a[c] !== exp_at(c)) begin
                    failures++;
                    $display("FAIL back_to_back stop=%0d cyc=%0d got=%h exp=%h",
                             p, c, obs_a[c], exp_at(c));
                end
            end
        end
    endtask

    task automatic test_underflow();
        clear_stim(1'b1);
        valid_a[6] = 1'b0;
        start_a[0] = 1'b1; stop_a[0] = 1'b1;
        s_cyc = 0; nf = 1; fc_base = 0; uf_carry = 1'b0;
        run(1'b1, 30);
        for (int c = 0; c < 30; c++) begin
            checks++;
            if (obs_a[c] !== exp_at(c)) begin
                failures++;
                $display("FAIL underflow cyc=%0d got=%h exp=%h", c, obs_a[c], exp_at(c));
            end
        end
        checks++;
        if (obs_a[29][16] !== 1'b1) begin
            failures++;
            $display("FAIL underflow_sticky got=%b exp=1", obs_a[29][16]);
        end
        // Second run without reset: idle stop ignored, start clears underflow
        clear_stim(1'b0);
        stop_a[0] = 1'b1;
        start_a[3] = 1'b1;
        stop_a[3 + FRAME + 1] = 1'b1;
        s_cyc = 3; nf = 2; fc_base = 1; uf_carry = 1'b1;
        run(1'b0, 48);
        for (int c = 0; c < 48; c++) begin
            checks++;
            if (obs_a[c] !== exp_at(c)) begin
                failures++;
                $display("FAIL underflow_restart cyc=%0d got=%h exp=%h", c, obs_a[c], exp_at(c));
            end
        end
    endtask

    task automatic test_start_while_busy();
        clear_stim(1'b0);
        start_a[0] = 1'b1; stop_a[0] = 1'b1;
        start_a[5] = 1'b1; start_a[12] = 1'b1;
        start_a[$urandom_range(1, FRAME - 1)] = 1'b1;
        s_cyc = 0; nf = 1; fc_base = 0; uf_carry = 1'b0;
        run(1'b1, 30);
        for (int c = 0; c < 30; c++) begin
            checks++;
            if (obs_a[c] !== exp_at(c)) begin
                failures++;
                $display("FAIL start_busy cyc=%0d got=%h exp=%h", c, obs_a[c], exp_at(c));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [28:0] e;
        clear_stim(1'b0);
        start_a[0] = 1'b1; stop_a[0] = 1'b1;
        s_cyc = 0; nf = 1; fc_base = 0; uf_carry = 1'b0;
        run(1'b1, 8);
        e = exp_at(8);
        checks++;
        if (cam_href !== e[27]) begin
            failures++;
            $display("FAIL pre_reset_href got=%b exp=%b", cam_href, e[27]);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({cam_vsync, cam_href, cam_dout, pix_ready, busy, underflow, frame_cnt} !== 29'h0) begin
            failures++;
            $display("FAIL async_reset got=%h exp=%h",
                     {cam_vsync, cam_href, cam_dout, pix_ready, busy, underflow, frame_cnt}, 29'h0);
        end
        clear_stim(1'b0);
        start_a[0] = 1'b1; stop_a[0] = 1'b1;
        run(1'b1, 30);
        for (int c = 0; c < 30; c++) begin
            checks++;
            if (obs_a[c] !== exp_at(c)) begin
                failures++;
                $display("FAIL post_reset cyc=%0d got=%h exp=%h", c, obs_a[c], exp_at(c));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_underflow();
        test_start_while_busy();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
